// File: rtl/fetch_stage.sv
// PC generation and instruction fetch for the 5-stage MIPS core.
// Drives the synchronous inst SRAM (data returns one cycle after address)
// and holds the IF/ID register feeding the decoder.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        dec_in_delayslot,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_in_delayslot,
  output logic        id_adel,
  output logic [31:0] if_pc
);

  logic [31:0] pc_q, npc;
  logic        if_valid_q;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_ds_q, id_ds_d;
  logic        id_adel_q, id_adel_d;
  logic        if_adel;

  // Next-PC select. Stall re-issues pc_q so rdata is still valid for the
  // held IF slot once the stall lifts. br_taken only counts with a real
  // instruction in ID.
  always_comb begin
    npc = pc_q + 32'd4;
    if (flush)                       npc = flush_pc;
    else if (!if_valid_q)            npc = RESET_PC;
    else if (stall)                  npc = pc_q;
    else if (br_taken && id_valid_q) npc = br_target;
  end

  assign inst_sram_addr  = npc;
  assign inst_sram_en    = resetn && (npc[1:0] == 2'b00);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign if_pc           = pc_q;

  assign if_adel = if_valid_q && (pc_q[1:0] != 2'b00);

  // IF/ID next state: flush kills, stall holds, else capture the IF slot.
  // The delay slot is captured regardless of br_taken.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_ds_d    = id_ds_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = 32'd0;
      id_ds_d    = 1'b0;
      id_adel_d  = 1'b0;
    end else if (!stall) begin
      id_valid_d = if_valid_q;
      id_pc_d    = pc_q;
      id_adel_d  = if_adel;
      id_inst_d  = (if_adel || !if_valid_q) ? 32'd0 : inst_sram_rdata;
      id_ds_d    = id_valid_q && dec_in_delayslot;
    end
  end

  // PC and IF/ID state registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
      id_ds_q    <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      pc_q       <= npc;
      if_valid_q <= 1'b1;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_ds_q    <= id_ds_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign id_valid        = id_valid_q;
  assign id_pc           = id_pc_q;
  assign id_inst         = id_inst_q;
  assign id_in_delayslot = id_ds_q;
  assign id_adel         = id_adel_q;

endmodule
